// File: rtl/disp_bcd_scan_ctrl.sv
// Binary-to-BCD front end for a 4-digit multiplexed seven-segment display.
// Iterative double-dabble conversion, registered digit outputs and a free-running scan prescaler.
module disp_bcd_scan_ctrl #(
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             bin_ready,
  output logic [1:0]       scan_sel,
  output logic [3:0]       dig_a,
  output logic [3:0]       dig_b,
  output logic [3:0]       dig_c,
  output logic [3:0]       dig_d,
  output logic             ovf
);

  localparam int IW = $clog2(BIN_W + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [3:0] LZ_RST = (BLANK_LZ != 0) ? 4'hF : 4'h0;
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(9999);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_q;
  logic [BIN_W-1:0] shreg_q;
  logic [15:0]      bcd_q;
  logic [IW-1:0]    iter_q;
  logic             pend_ovf_q;
  logic [3:0]       dig_a_q, dig_b_q, dig_c_q, dig_d_q;
  logic             ovf_q;
  logic [PW-1:0]    presc_q;
  logic [1:0]       scan_q;

  logic [15:0]          bcd_adj;
  logic [16+BIN_W-1:0]  cat_d;
  logic [BIN_W-1:0]     bin_clamped;
  logic                 bin_over;
  logic                 blank_d, blank_c, blank_b;
  logic                 xfer;

  // Add-3 correction on every BCD nibble that would overflow after doubling.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                             : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign cat_d       = {bcd_adj, shreg_q} << 1;
  assign bin_over    = (bin_in > MAX_VAL);
  assign bin_clamped = bin_over ? MAX_VAL : bin_in;

  assign blank_d = (BLANK_LZ != 0) && (bcd_q[15:12] == 4'd0);
  assign blank_c = blank_d && (bcd_q[11:8] == 4'd0);
  assign blank_b = blank_c && (bcd_q[7:4] == 4'd0);

  assign bin_ready = (state_q == IDLE) && rst_n;
  assign xfer      = bin_valid && bin_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      pend_ovf_q <= 1'b0;
      dig_a_q    <= 4'h0;
      dig_b_q    <= LZ_RST;
      dig_c_q    <= LZ_RST;
      dig_d_q    <= LZ_RST;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            shreg_q    <= bin_clamped;
            bcd_q      <= '0;
            iter_q     <= '0;
            pend_ovf_q <= bin_over;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q   <= cat_d[16+BIN_W-1:BIN_W];
          shreg_q <= cat_d[BIN_W-1:0];
          iter_q  <= iter_q + IW'(1);
          if (iter_q == IW'(BIN_W - 1)) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          dig_a_q <= bcd_q[3:0];
          dig_b_q <= blank_b ? 4'hF : bcd_q[7:4];
          dig_c_q <= blank_c ? 4'hF : bcd_q[11:8];
          dig_d_q <= blank_d ? 4'hF : bcd_q[15:12];
          ovf_q   <= pend_ovf_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Scan prescaler runs regardless of conversion activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      scan_q  <= 2'd0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      scan_q  <= scan_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign scan_sel = scan_q;
  assign dig_a    = dig_a_q;
  assign dig_b    = dig_b_q;
  assign dig_c    = dig_c_q;
  assign dig_d    = dig_d_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_disp_bcd_scan_ctrl.sv
// Scoreboard bench: two instances (leading-zero blanking on and off) share stimulus;
// expected digits are computed arithmetically and checked when each commit falls due.
module tb_disp_bcd_scan_ctrl;

  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int LAT      = BIN_W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [BIN_W-1:0] bin_in;
  logic             bin_valid;
  logic             ready1, ready0;
  logic [1:0]       scan1, scan0;
  logic [3:0]       a1, b1, c1, d1, a0, b0, c0, d0;
  logic             ovf1, ovf0;

  disp_bcd_scan_ctrl #(.BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut_lz1 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid), .bin_ready(ready1),
    .scan_sel(scan1), .dig_a(a1), .dig_b(b1), .dig_c(c1), .dig_d(d1), .ovf(ovf1));

  disp_bcd_scan_ctrl #(.BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_lz0 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid), .bin_ready(ready0),
    .scan_sel(scan0), .dig_a(a0), .dig_b(b0), .dig_c(c0), .dig_d(d0), .ovf(ovf0));

  always #5 clk = ~clk;

  typedef struct {
    int          val;
    logic [15:0] dg1;
    logic [15:0] dg0;
    logic        ov;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   scan_n = 0;
  bit   rst_seen = 0;
  bit   armed = 0;
  logic [15:0] cur1, cur0;
  logic        cur_ovf;

  // Display digits {thousands, hundreds, tens, ones} from plain decimal arithmetic.
  function automatic logic [15:0] model_digits(int v, bit lz);
    int c;
    logic [3:0] th, hu, te, on;
    c  = (v > 9999) ? 9999 : v;
    th = 4'(c / 1000);
    hu = 4'((c / 100) % 10);
    te = 4'((c / 10) % 10);
    on = 4'(c % 10);
    if (lz && c < 1000) th = 4'hF;
    if (lz && c < 100)  hu = 4'hF;
    if (lz && c < 10)   te = 4'hF;
    return {th, hu, te, on};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Edge observer: records resets and accepted transfers (values sampled before the edge).
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      rst_seen = 1;
      scan_n   = 0;
    end else begin
      scan_n++;
      if (bin_valid && ready1) begin
        e.val = int'(bin_in);
        e.dg1 = model_digits(int'(bin_in), 1'b1);
        e.dg0 = model_digits(int'(bin_in), 1'b0);
        e.ov  = (int'(bin_in) > 9999);
        e.due = cyc + LAT;
        q.push_back(e);
      end
    end
  end

  // Monitor: pops the expected result when its commit edge arrives and checks all outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      q.delete();
      cur1     = 16'hFFF0;
      cur0     = 16'h0000;
      cur_ovf  = 1'b0;
      armed    = 1;
      rst_seen = 0;
    end
    if (armed) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        cur1    = e.dg1;
        cur0    = e.dg0;
        cur_ovf = e.ov;
        $display("commit cycle %0d in=%0d lz1=%h lz0=%h ovf=%0b dut=%h/%h/%0b",
                 cyc, e.val, e.dg1, e.dg0, e.ov, {d1, c1, b1, a1}, {d0, c0, b0, a0}, ovf1);
      end
      chk("digits_lz1", 32'({d1, c1, b1, a1}), 32'(cur1));
      chk("digits_lz0", 32'({d0, c0, b0, a0}), 32'(cur0));
      chk("ovf_lz1", 32'(ovf1), 32'(cur_ovf));
      chk("ovf_lz0", 32'(ovf0), 32'(cur_ovf));
      chk("ready_lz1", 32'(ready1), 32'(rst_n && q.size() == 0));
      chk("ready_lz0", 32'(ready0), 32'(rst_n && q.size() == 0));
      chk("scan_lz1", 32'(scan1), 32'((scan_n / SCAN_DIV) % 4));
      chk("scan_lz0", 32'(scan0), 32'((scan_n / SCAN_DIV) % 4));
    end
  end

  // Present a value and hold it until it is accepted.
  task automatic send(int v);
    bit done;
    done = 0;
    bin_in    = BIN_W'(v);
    bin_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (ready1) begin
        done = 1;
        break;
      end
    end
    #1;
    bin_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept value %0d: got no acceptance expected acceptance within 100 cycles", v);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        done = 1;
        break;
      end
    end
    #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
  endtask

  int plan[$] = '{1234, 9999, 10000, 16383, 5, 7, 40, 300, 0};

  initial begin
    rst_n     = 1'b0;
    bin_valid = 1'b0;
    bin_in    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    foreach (plan[i]) begin
      send(plan[i]);
      wait_idle();
    end

    // A second value offered mid-conversion must wait for the first to commit.
    send(1234);
    repeat (3) @(posedge clk);
    #1;
    send(42);
    wait_idle();

    // Reset in the middle of a conversion discards it.
    send(8765);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      send(int'($urandom_range(0, 16383)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 10; i++) begin
      send(int'($urandom_range(0, 120)));
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
